sipo_reg_rx: RTL and testbench
==============================

# sipo_reg_rx

Serial-in, parallel-out receiver: the receiving end of the PISO serial link. Collects N MSB-first bits, one per `clk` edge while `shift_en` is high, and presents each completed word on a one-entry valid/ready output buffer. Sits between the serial line and the parallel consumer logic, with full throughput for back-to-back words.

## Interface
- `N`, 8: word width in bits (≥2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `shift_en`  input  1  sample `s_data` on this edge
- `s_data`  input  1  serial data, MSB first
- `frame_clr`  input  1  realign: discard the partial word, bit count to 0
- `p_data`  output  N  completed word, stable while `p_valid`
- `p_valid`  output  1  output buffer holds an unconsumed word
- `p_ready`  input  1  consumer accepts on an edge with `p_valid && p_ready`
- `overrun`  output  1  one-cycle pulse: a completed word was dropped
- `bit_cnt`  output  $clog2(N)  bits collected in the current partial word

## Operation
- **Reset:** `rst` high at an edge clears `shreg`, `bit_cnt`, `p_data`, `p_valid` and `overrun` to 0. `rst` overrides every other input, including mid-word.
- **Shift:** when `shift_en` is high and `frame_clr` is low:
  - `shreg <= {shreg[N-2:0], s_data}`
  - `bit_cnt` increments and wraps N-1 → 0.
- **Word complete:** an edge with `shift_en` high and `bit_cnt == N-1`:
  - The candidate word is `{shreg[N-2:0], s_data}`.
  - If the buffer is free, the word loads into `p_data` and `p_valid` is set to 1. The buffer is free when `p_valid == 0`, or when `p_valid && p_ready` on the same edge (simultaneous drain and refill).
  - Otherwise the word is dropped, `p_data` and `p_valid` are unchanged, and `overrun` is 1 for the next cycle.
- **Consume:** `p_valid && p_ready` with no word completing on that edge clears `p_valid`. `p_data` holds its last value.
- **frame_clr:** `bit_cnt <= 0` and `shreg <= 0`. The output buffer is untouched.
  - With simultaneous `shift_en`, `frame_clr` wins and that bit is discarded.
  - With a completing edge, no word is produced.
- **Output registers:** `overrun` is 0 on every edge other than a drop edge. All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- **Latency:** the Nth bit is sampled at edge k; `p_valid` and `p_data` are updated after edge k and are visible in cycle k+1.
- **Throughput:** continuous `shift_en` with `p_ready` held high gives one word every N cycles with no bubbles.
- **Gaps:** `shift_en` low freezes `shreg` and `bit_cnt`. Gaps of any length are allowed mid-word.
- **`p_ready` low:** `p_valid` stays high and `p_data` is stable until the accepting edge.
- **Overrun window:** a drop occurs only if the consumer stalls through an entire following word, N shift edges.
- **Reset release:** the first shift edge after `rst` falls counts as bit 0.

## Structure
- **Shared package `piso_pkg`:**
  - `DEFAULT_N = 8`
  - `CNT_W(N) = $clog2(N)` helper
  - word typedef `logic [DEFAULT_N-1:0] word_t`
- The PISO transmitter and this receiver both import the package.
- **State:** no FSM; the state is `bit_cnt` plus `p_valid`.
- **Sub-module `sipo_out_buf`:** the natural split is a one-entry valid/ready holding register with a `load`/`drop` indication. The shift register and counter stay inline.

## Test plan
1. **Reset:** hold `rst` for 2 cycles with `shift_en=1` → `p_valid=0`, `p_data=0`, `bit_cnt=0`, `overrun=0` throughout.
2. **Single word:** shift 1,1,0,1,0,1,1,0 with `p_ready=0` → after the 8th edge, `p_data=8'hD6` and `p_valid=1`; both hold; one `p_ready` edge clears `p_valid`.
3. **Back-to-back:** send 0xD6 then 0x3C continuously with `p_ready=1` → `p_valid` pulses in cycles 9 and 17 with `p_data` 0xD6 then 0x3C; `overrun` stays 0.
4. **Overrun:** `p_ready=0`, send 0xA5 then 0x5A → `p_data` stays 0xA5 and `overrun` pulses once after the 16th edge. With `p_ready=1` on the 16th edge instead → 0x5A loads and there is no overrun.
5. **frame_clr:** shift 3 bits, assert `frame_clr` together with `shift_en`, then shift 0xF0 → `bit_cnt=0` after the clear edge; the next word is 0xF0.
6. **Reset mid-word:** `rst` after 5 bits, then shift 0x81 → `p_data=0x81`, with no residue from the partial word.

Source files
------------

// File: rtl/piso_pkg.sv
// Definitions shared by the PISO transmitter and the SIPO receiver
// (default word width, word type and counter-width helper).
package piso_pkg;

  localparam int DEFAULT_N = 8;

  typedef logic [DEFAULT_N-1:0] word_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words. A completed word
// loads when the buffer is free (empty or draining this edge); otherwise it is dropped.
module sipo_out_buf
  import piso_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_done,
  input  logic [N-1:0] word_in,
  input  logic         p_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  output logic         overrun
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic         load_s;
  logic         drop_s;

  always_comb begin
    load_s    = word_done && (!valid_q || p_ready);
    drop_s    = word_done && valid_q && !p_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_s) begin
      data_d  = word_in;
      valid_d = 1'b1;
    end else if (drop_s) begin
      overrun_d = 1'b1;
    end else if (valid_q && p_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= {N{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_data  = data_q;
  assign p_valid = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/sipo_reg_rx.sv
// Serial-in, parallel-out receiver: collects N MSB-first bits while shift_en is
// high and hands each completed word to a one-entry valid/ready output buffer.
module sipo_reg_rx
  import piso_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                s_data,
  input  logic                frame_clr,
  output logic [N-1:0]        p_data,
  output logic                p_valid,
  input  logic                p_ready,
  output logic                overrun,
  output logic [cnt_w(N)-1:0] bit_cnt
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  // Only N-1 history bits are kept: the oldest bit of a full shift register
  // would be shifted out on the completing edge and is never observable.
  logic [N-2:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  word_s;
  logic          word_done_s;

  always_comb begin
    word_s      = {shreg_q, s_data};
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_s = 1'b0;
    if (frame_clr) begin
      shreg_d = {(N-1){1'b0}};
      cnt_d   = {CW{1'b0}};
    end else if (shift_en) begin
      shreg_d     = word_s[N-2:0];
      word_done_s = (cnt_q == CNT_MAX);
      if (cnt_q == CNT_MAX) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= {(N-1){1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

  sipo_out_buf #(
    .N (N)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .word_done (word_done_s),
    .word_in   (word_s),
    .p_ready   (p_ready),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sipo_reg_rx.sv
// Self-checking bench for sipo_reg_rx: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_sipo_reg_rx;
  import piso_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         shift_en = 1'b0;
  logic         s_data = 1'b0;
  logic         frame_clr = 1'b0;
  logic         p_ready = 1'b0;
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         overrun;
  logic [2:0]   bit_cnt;

  sipo_reg_rx #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .s_data    (s_data),
    .frame_clr (frame_clr),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits received so far in the current word, plus the buffer.
  bit           q_bits[$];
  logic [N-1:0] exp_data  = '0;
  logic         exp_valid = 1'b0;
  logic         exp_ovr   = 1'b0;

  // One clock: drive inputs at negedge, advance model, sample 1 time unit after posedge.
  task automatic cyc(input logic r, input logic se, input logic sd, input logic fc, input logic pr);
    logic [N-1:0] w;
    logic         done;
    @(negedge clk);
    rst = r; shift_en = se; s_data = sd; frame_clr = fc; p_ready = pr;
    done = 1'b0;
    w    = '0;
    if (r) begin
      q_bits.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      exp_ovr = 1'b0;
      if (fc) begin
        q_bits.delete();
      end else if (se) begin
        q_bits.push_back(sd);
        if (q_bits.size() == N) begin
          foreach (q_bits[i]) w = w + (N'(q_bits[i]) << (N - 1 - i));
          done = 1'b1;
          q_bits.delete();
        end
      end
      if (done) begin
        if (!exp_valid || pr) begin
          exp_data  = w;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && pr) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic pr);
    for (int i = N - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i], 1'b0, pr);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({p_valid, p_data, bit_cnt, overrun} !== 12'h000) begin
        n_errors++;
        $display("FAIL reset cyc %0d got v=%b d=%h cnt=%0d ovr=%b exp all zero", i, p_valid, p_data, bit_cnt, overrun);
      end
    end
  endtask

  task automatic test_single_word();
    send_word(8'hD6, 1'b0);
    n_checks++;
    if ({p_valid, p_data} !== {1'b1, 8'hD6}) begin
      n_errors++;
      $display("FAIL single_word got v=%b d=%h exp v=1 d=d6", p_valid, p_data);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({p_valid, p_data} !== {1'b1, 8'hD6}) begin
        n_errors++;
        $display("FAIL single_hold %0d got v=%b d=%h exp v=1 d=d6", i, p_valid, p_data);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({p_valid, p_data} !== {1'b0, 8'hD6}) begin
      n_errors++;
      $display("FAIL single_consume got v=%b d=%h exp v=0 d=d6", p_valid, p_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic        want_v;
    bits = 16'hD63C;
    for (int j = 0; j < 16; j++) begin
      cyc(1'b0, 1'b1, bits[15-j], 1'b0, 1'b1);
      want_v = (j == 7) || (j == 15);
      n_checks++;
      if ({p_valid, overrun} !== {want_v, 1'b0}) begin
        n_errors++;
        $display("FAIL b2b_valid edge %0d got v=%b ovr=%b exp v=%b ovr=0", j + 1, p_valid, overrun, want_v);
      end
      if (want_v) begin
        n_checks++;
        if (p_data !== ((j == 7) ? 8'hD6 : 8'h3C)) begin
          n_errors++;
          $display("FAIL b2b_data edge %0d got %h exp %h", j + 1, p_data, (j == 7) ? 8'hD6 : 8'h3C);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [N-1:0] w;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    n_checks++;
    if ({p_valid, p_data, overrun} !== {1'b1, 8'hA5, 1'b1}) begin
      n_errors++;
      $display("FAIL overrun_drop got v=%b d=%h ovr=%b exp v=1 d=a5 ovr=1", p_valid, p_data, overrun);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({p_data, overrun} !== {8'hA5, 1'b0}) begin
      n_errors++;
      $display("FAIL overrun_pulse got d=%h ovr=%b exp d=a5 ovr=0", p_data, overrun);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    w = 8'h5A;
    for (int i = N - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i], 1'b0, (i == 0));
    n_checks++;
    if ({p_valid, p_data, overrun} !== {1'b1, 8'h5A, 1'b0}) begin
      n_errors++;
      $display("FAIL overrun_refill got v=%b d=%h ovr=%b exp v=1 d=5a ovr=0", p_valid, p_data, overrun);
    end
  endtask

  task automatic test_frame_clr();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bit_cnt !== 3'd3) begin
      n_errors++;
      $display("FAIL fclr_partial got cnt=%0d exp 3", bit_cnt);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bit_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL fclr_cnt got cnt=%0d exp 0", bit_cnt);
    end
    send_word(8'hF0, 1'b0);
    n_checks++;
    if ({p_valid, p_data} !== {1'b1, 8'hF0}) begin
      n_errors++;
      $display("FAIL fclr_word got v=%b d=%h exp v=1 d=f0", p_valid, p_data);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({p_valid, p_data, bit_cnt, overrun} !== 12'h000) begin
      n_errors++;
      $display("FAIL rst_mid_clear got v=%b d=%h cnt=%0d ovr=%b exp all zero", p_valid, p_data, bit_cnt, overrun);
    end
    send_word(8'h81, 1'b0);
    n_checks++;
    if ({p_valid, p_data} !== {1'b1, 8'h81}) begin
      n_errors++;
      $display("FAIL rst_mid_word got v=%b d=%h exp v=1 d=81", p_valid, p_data);
    end
  endtask

  task automatic test_random();
    logic r, se, sd, fc, pr;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      se = ($urandom_range(0, 3) != 0);
      sd = 1'($urandom_range(0, 1));
      fc = ($urandom_range(0, 39) == 0);
      pr = ($urandom_range(0, 2) == 0);
      cyc(r, se, sd, fc, pr);
      n_checks++;
      if ({p_valid, p_data, bit_cnt, overrun} !== {exp_valid, exp_data, 3'(q_bits.size()), exp_ovr}) begin
        n_errors++;
        $display("FAIL random cyc %0d got v=%b d=%h cnt=%0d ovr=%b exp v=%b d=%h cnt=%0d ovr=%b",
                 i, p_valid, p_data, bit_cnt, overrun, exp_valid, exp_data, q_bits.size(), exp_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_frame_clr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
